// File: rtl/hub75_pkg.sv
// hub75_pkg: state encoding and shared constants for the HUB75 scan sequencer.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    BLANK,
    GHOST,
    LATCH,
    UNBLANK,
    DRAIN
  } scan_state_e;

  // Anti-ghosting dead time on each side of the latch, in clk cycles.
  localparam int unsigned GHOST_CYC  = 4;
  localparam int unsigned BCM_BASE_W = 8;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// hub75_scan_ctrl_if: pixel stream in, PHY drive out.
// master = scan sequencer, slave = the pixel source / PHY side.
interface hub75_scan_ctrl_if #(
  parameter int unsigned SDW        = 6,
  parameter int unsigned LOG_N_ROWS = 5
);
  logic [SDW-1:0]        px_data;
  logic                  px_valid;
  logic                  px_ready;
  logic [LOG_N_ROWS-1:0] phy_addr;
  logic                  phy_addr_inc;
  logic                  phy_addr_rst;
  logic [SDW-1:0]        phy_data;
  logic                  phy_clk;
  logic                  phy_le;
  logic                  phy_blank;

  modport master (
    input  px_data, px_valid,
    output px_ready, phy_addr, phy_addr_inc, phy_addr_rst,
           phy_data, phy_clk, phy_le, phy_blank
  );

  modport slave (
    output px_data, px_valid,
    input  px_ready, phy_addr, phy_addr_inc, phy_addr_rst,
           phy_data, phy_clk, phy_le, phy_blank
  );
endinterface

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: BCM on-time down-counter. Loads max(base,1) << shift,
// then counts down to zero and stays there.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int unsigned TW = 15,
  parameter int unsigned SW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BCM_BASE_W-1:0] base,
  input  logic [SW-1:0]         shift,
  output logic                  zero_c
);

  logic [TW-1:0]         cnt_q;
  logic [BCM_BASE_W-1:0] base_eff;

  assign base_eff = (base == '0) ? BCM_BASE_W'(1) : base;

  // Load on request, otherwise decrement while nonzero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TW'(base_eff) << shift;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  // High on the last on-cycle: count is zero now or reaches zero at this edge.
  assign zero_c = (cnt_q <= TW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 scan sequencer. Shifts one row-plane per pass,
// blanks, latches, advances the displayed row, then unblanks for a
// binary-weighted on-time while the next row-plane shifts in.
// Optional macro HUB75_SCAN_GHOST_EN adds GHOST_CYC blanked cycles before
// and after the latch.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int unsigned N_BANKS  = 2,
  parameter int unsigned N_ROWS   = 32,
  parameter int unsigned N_COLS   = 64,
  parameter int unsigned N_CHANS  = 3,
  parameter int unsigned N_PLANES = 8,
  localparam int unsigned SDW        = N_BANKS * N_CHANS,
  localparam int unsigned LOG_N_ROWS = $clog2(N_ROWS),
  localparam int unsigned PW         = idx_w(N_PLANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_run,
  input  logic [BCM_BASE_W-1:0]  cfg_bcm_base,
  output logic [LOG_N_ROWS-1:0]  cur_row,
  output logic [PW-1:0]          cur_plane,
  output logic                   line_start,
  output logic                   frame_end,
  hub75_scan_ctrl_if.master      bus
);

  localparam int unsigned CW = idx_w(N_COLS);
  localparam int unsigned TW = BCM_BASE_W + N_PLANES - 1;

  scan_state_e           state_q, state_d;
  logic                  px_ready_q, px_ready_d;
  logic                  line_start_q, line_start_d;
  logic                  frame_end_q, frame_end_d;
  logic [LOG_N_ROWS-1:0] phy_addr_q, phy_addr_d;
  logic                  addr_inc_q, addr_inc_d;
  logic                  addr_rst_q, addr_rst_d;
  logic [SDW-1:0]        phy_data_q, phy_data_d;
  logic                  phy_clk_q, phy_clk_d;
  logic                  phy_le_q, phy_le_d;
  logic                  phy_blank_q, phy_blank_d;
  logic [LOG_N_ROWS-1:0] row_q, row_d;
  logic [PW-1:0]         plane_q, plane_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  tmr_load;
  logic                  tmr_zero_c;
  logic                  enter_latch;
  logic                  frame_wrap;

`ifdef HUB75_SCAN_GHOST_EN
  localparam int unsigned GW = idx_w(GHOST_CYC);
  logic [GW-1:0] ghost_cnt_q, ghost_cnt_d;
  logic          ghost_post_q, ghost_post_d;

  // Dead-time counter and pre/post-latch phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghost_cnt_q  <= '0;
      ghost_post_q <= 1'b0;
    end else begin
      ghost_cnt_q  <= ghost_cnt_d;
      ghost_post_q <= ghost_post_d;
    end
  end
`endif

  hub75_bcm_timer #(
    .TW (TW),
    .SW (PW)
  ) u_bcm_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .base   (cfg_bcm_base),
    .shift  (plane_q),
    .zero_c (tmr_zero_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      px_ready_q   <= 1'b0;
      line_start_q <= 1'b0;
      frame_end_q  <= 1'b0;
      phy_addr_q   <= '0;
      addr_inc_q   <= 1'b0;
      addr_rst_q   <= 1'b0;
      phy_data_q   <= '0;
      phy_clk_q    <= 1'b0;
      phy_le_q     <= 1'b0;
      phy_blank_q  <= 1'b1;
      row_q        <= '0;
      plane_q      <= '0;
      col_q        <= '0;
    end else begin
      state_q      <= state_d;
      px_ready_q   <= px_ready_d;
      line_start_q <= line_start_d;
      frame_end_q  <= frame_end_d;
      phy_addr_q   <= phy_addr_d;
      addr_inc_q   <= addr_inc_d;
      addr_rst_q   <= addr_rst_d;
      phy_data_q   <= phy_data_d;
      phy_clk_q    <= phy_clk_d;
      phy_le_q     <= phy_le_d;
      phy_blank_q  <= phy_blank_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      col_q        <= col_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    px_ready_d   = px_ready_q;
    line_start_d = 1'b0;
    frame_end_d  = 1'b0;
    phy_addr_d   = phy_addr_q;
    addr_inc_d   = 1'b0;
    addr_rst_d   = 1'b0;
    phy_data_d   = phy_data_q;
    phy_clk_d    = 1'b0;
    phy_le_d     = 1'b0;
    phy_blank_d  = phy_blank_q;
    row_d        = row_q;
    plane_d      = plane_q;
    col_d        = col_q;
    tmr_load     = 1'b0;
    enter_latch  = 1'b0;
    frame_wrap   = 1'b0;
`ifdef HUB75_SCAN_GHOST_EN
    ghost_cnt_d  = ghost_cnt_q;
    ghost_post_d = ghost_post_q;
`endif

    // On-time expiry blanks the LEDs whatever the sequencer is doing, so the
    // lit duration is exactly the programmed weight even if the shift stalls.
    if (tmr_zero_c) phy_blank_d = 1'b1;

    case (state_q)
      IDLE: begin
        phy_blank_d = 1'b1;
        if (ctrl_run) begin
          state_d      = SHIFT;
          row_d        = '0;
          plane_d      = '0;
          col_d        = '0;
          px_ready_d   = 1'b1;
          line_start_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.px_valid && px_ready_q) begin
          phy_data_d = bus.px_data;
          phy_clk_d  = 1'b1;
          if (col_q == CW'(N_COLS - 1)) begin
            col_d      = '0;
            px_ready_d = 1'b0;
            state_d    = WAIT;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      WAIT: begin
        if (tmr_zero_c) state_d = BLANK;
      end
      BLANK: begin
        phy_blank_d = 1'b1;
`ifdef HUB75_SCAN_GHOST_EN
        state_d      = GHOST;
        ghost_cnt_d  = '0;
        ghost_post_d = 1'b0;
`else
        enter_latch = 1'b1;
`endif
      end
      GHOST: begin
        phy_blank_d = 1'b1;
`ifdef HUB75_SCAN_GHOST_EN
        if (ghost_cnt_q == GW'(GHOST_CYC - 1)) begin
          if (ghost_post_q) state_d = UNBLANK;
          else              enter_latch = 1'b1;
        end else begin
          ghost_cnt_d = ghost_cnt_q + GW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      LATCH: begin
        phy_blank_d = 1'b1;
`ifdef HUB75_SCAN_GHOST_EN
        state_d      = GHOST;
        ghost_cnt_d  = '0;
        ghost_post_d = 1'b1;
`else
        state_d = UNBLANK;
`endif
      end
      UNBLANK: begin
        phy_blank_d = 1'b0;
        tmr_load    = 1'b1;
        if (plane_q == PW'(N_PLANES - 1)) begin
          plane_d = '0;
          if (row_q == LOG_N_ROWS'(N_ROWS - 1)) begin
            row_d       = '0;
            frame_end_d = 1'b1;
            frame_wrap  = 1'b1;
          end else begin
            row_d = row_q + LOG_N_ROWS'(1);
          end
        end else begin
          plane_d = plane_q + PW'(1);
        end
        if (frame_wrap && !ctrl_run) begin
          state_d = DRAIN;
        end else begin
          state_d      = SHIFT;
          line_start_d = 1'b1;
          px_ready_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (tmr_zero_c) begin
          phy_blank_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering LATCH: strobe LE and move the displayed address to the shifted row.
    if (enter_latch) begin
      state_d    = LATCH;
      phy_le_d   = 1'b1;
      phy_addr_d = row_q;
      if (row_q != phy_addr_q) begin
        if (row_q == '0) addr_rst_d = 1'b1;
        else             addr_inc_d = 1'b1;
      end
    end
  end

  assign cur_row          = row_q;
  assign cur_plane        = plane_q;
  assign line_start       = line_start_q;
  assign frame_end        = frame_end_q;
  assign bus.px_ready     = px_ready_q;
  assign bus.phy_addr     = phy_addr_q;
  assign bus.phy_addr_inc = addr_inc_q;
  assign bus.phy_addr_rst = addr_rst_q;
  assign bus.phy_data     = phy_data_q;
  assign bus.phy_clk      = phy_clk_q;
  assign bus.phy_le       = phy_le_q;
  assign bus.phy_blank    = phy_blank_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: directed bench for a 4x4 panel, 4 columns, 2 planes, base 8.
module tb_hub75_scan_ctrl;

  localparam int unsigned N_BANKS  = 2;
  localparam int unsigned N_ROWS   = 4;
  localparam int unsigned N_COLS   = 4;
  localparam int unsigned N_CHANS  = 3;
  localparam int unsigned N_PLANES = 2;
  localparam int unsigned SDW      = N_BANKS * N_CHANS;
  localparam int unsigned LRW      = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ctrl_run = 1'b0;
  logic [7:0]     cfg_bcm_base = 8'd8;
  logic [LRW-1:0] cur_row;
  logic [0:0]     cur_plane;
  logic           line_start;
  logic           frame_end;

  hub75_scan_ctrl_if #(.SDW(SDW), .LOG_N_ROWS(LRW)) bus ();

  hub75_scan_ctrl #(
    .N_BANKS  (N_BANKS),
    .N_ROWS   (N_ROWS),
    .N_COLS   (N_COLS),
    .N_CHANS  (N_CHANS),
    .N_PLANES (N_PLANES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_run     (ctrl_run),
    .cfg_bcm_base (cfg_bcm_base),
    .cur_row      (cur_row),
    .cur_plane    (cur_plane),
    .line_start   (line_start),
    .frame_end    (frame_end),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Event log filled by the monitor.
  int        n_clk = 0;
  int        n_le  = 0;
  int        n_fe  = 0;
  int        n_ls  = 0;
  int        blank_len = 0;
  int        le_clk[$];
  int        le_addr[$];
  int        fe_le[$];
  int        fe_clk[$];
  int        blank_runs[$];
  int        events[$];
  logic [5:0] data_q[$];

  // Pixel source state.
  int px_val     = 0;
  bit hs_pending = 1'b0;
  bit valid_mode = 1'b0;

  int exp_ev[8] = '{11, 12, 13, 20, 11, 12, 13, 20};
  int c0;
  int le0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: advance the pixel source past any completed handshake.
  task automatic tick();
    @(negedge clk);
    if (hs_pending) px_val++;
    if (valid_mode) bus.px_valid = ~bus.px_valid;
    else            bus.px_valid = 1'b1;
    bus.px_data = 6'(px_val);
    hs_pending  = bus.px_valid && bus.px_ready && !rst;
  endtask

  // Monitor: sampled on the falling edge, away from output updates.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        blank_len = 0;
      end else begin
        if (bus.phy_clk) begin
          n_clk++;
          data_q.push_back(bus.phy_data);
        end
        if (bus.phy_le) begin
          n_le++;
          le_clk.push_back(n_clk);
          le_addr.push_back(int'(bus.phy_addr));
        end
        if (line_start) n_ls++;
        if (bus.phy_addr_inc) events.push_back(10 + int'(bus.phy_addr));
        if (bus.phy_addr_rst) events.push_back(20 + int'(bus.phy_addr));
        if (frame_end) begin
          n_fe++;
          fe_le.push_back(n_le);
          fe_clk.push_back(n_clk);
        end
        if (!bus.phy_blank) begin
          blank_len++;
        end else if (blank_len != 0) begin
          blank_runs.push_back(blank_len);
          blank_len = 0;
        end
      end
    end
  end

  initial begin
    bus.px_valid = 1'b1;
    bus.px_data  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_px_ready", bus.px_ready, 0);
    check("rst_blank", bus.phy_blank, 1);
    check("rst_le", bus.phy_le, 0);
    check("rst_phy_clk", bus.phy_clk, 0);
    check("rst_addr", bus.phy_addr, 0);
    check("rst_row", cur_row, 0);
    check("rst_plane", cur_plane, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_end", frame_end, 0);

    // Idle with run low: nothing starts
    rst = 1'b0;
    repeat (4) tick();
    check("idle_ls", n_ls, 0);
    check("idle_blank", bus.phy_blank, 1);
    check("idle_px_ready", bus.px_ready, 0);

    // Frame 1 with continuous pixels
    ctrl_run = 1'b1;
    tick();
    check("start_ls", line_start, 1);
    check("start_px_ready", bus.px_ready, 1);
    check("start_row", cur_row, 0);
    for (int i = 0; i < 3000 && n_fe < 1; i++) tick();
    check("f1_timeout", n_fe >= 1, 1);
    check("f1_le", fe_le[0], 8);
    check("f1_clk", fe_clk[0], 32);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("f1_le_clk%0d", k), le_clk[k], 4 * (k + 1));
      check($sformatf("f1_le_addr%0d", k), le_addr[k], k / 2);
    end
    check("f1_data0", data_q[0], 0);
    check("f1_data31", data_q[31], 31);

    // Frame 2: drop run at row 1, frame must complete and drain
    for (int i = 0; i < 500 && cur_row != 2'd1; i++) tick();
    ctrl_run = 1'b0;
    check("drop_row", cur_row, 1);
    for (int i = 0; i < 3000 && n_fe < 2; i++) tick();
    check("f2_timeout", n_fe >= 2, 1);
    repeat (40) tick();
    check("f2_fe", n_fe, 2);
    check("f2_le", fe_le[1], 16);
    check("f2_clk", fe_clk[1], 64);
    check("drain_blank", bus.phy_blank, 1);
    check("drain_px_ready", bus.px_ready, 0);
    check("drain_addr", bus.phy_addr, 3);
    check("drain_ls", n_ls, 16);
    repeat (20) tick();
    check("idle_no_ls", n_ls, 16);
    check("runs_n", blank_runs.size(), 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("run%0d", k), blank_runs[k], (k % 2 == 0) ? 8 : 16);
    check("ev_n", events.size(), 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("ev%0d", k), events[k], exp_ev[k]);

    // Toggling px_valid
    valid_mode = 1'b1;
    ctrl_run   = 1'b1;
    tick();
    check("tog_ls", line_start, 1);
    for (int i = 0; i < 2000 && n_le < 18; i++) tick();
    check("tog_timeout", n_le >= 18, 1);
    check("tog_le_clk16", le_clk[16], 68);
    check("tog_le_clk17", le_clk[17], 72);
    for (int k = 0; k < 8; k++)
      check($sformatf("tog_data%0d", k), data_q[64 + k], 6'(k));
    check("tog_ev_n", events.size(), 8);
    check("tog_ev7", events[7], exp_ev[7]);

    // Reset in the middle of a shift
    for (int i = 0; i < 500 && n_clk < 74; i++) tick();
    check("mid_shift_timeout", n_clk >= 74, 1);
    rst = 1'b1;
    hs_pending = 1'b0;
    #1;
    check("mrst_blank", bus.phy_blank, 1);
    check("mrst_phy_clk", bus.phy_clk, 0);
    check("mrst_px_ready", bus.px_ready, 0);
    check("mrst_row", cur_row, 0);
    check("mrst_addr", bus.phy_addr, 0);
    tick();
    check("mrst_blank2", bus.phy_blank, 1);
    check("mrst_px_ready2", bus.px_ready, 0);
    rst = 1'b0;
    tick();
    check("restart_ls", line_start, 1);
    check("restart_row", cur_row, 0);
    check("restart_plane", cur_plane, 0);
    check("restart_px_ready", bus.px_ready, 1);
    c0  = n_clk;
    le0 = n_le;
    for (int i = 0; i < 500 && n_le < le0 + 1; i++) tick();
    check("restart_timeout", n_le >= le0 + 1, 1);
    check("restart_le_clk", le_clk[le0], c0 + 4);
    check("restart_le_addr", le_addr[le0], 0);
    check("restart_ev_n", events.size(), 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
